md_ctrl_unit: RTL
=================

// Module: md_ctrl_unit
// PURPOSE
//  Parametrised multiply/divide control unit for the 5-stage pipeline.
//  - Decodes MD-class instructions in D and E: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
//  - Sequences multi-cycle mult/div with a busy counter and owns the HI/LO registers.
//  - Drives the D-stage stall that the hazard unit ORs into its own stall term.
// PARAMETERS
//  DATA_W       32  operand / HI / LO width
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk      in   1       clock, rising edge
//  rst_n    in   1       asynchronous, active-low reset
//  instrD   in   32      D-stage instruction
//  instrE   in   32      E-stage instruction
//  validE   in   1       instrE is real, not a bubble or flushed slot
//  rsE      in   DATA_W  forwarded rs operand in E
//  rtE      in   DATA_W  forwarded rt operand in E
//  busy     out  1       mult/div in progress
//  stallD   out  1       hold D; insert bubble into E
//  hi       out  DATA_W  HI register
//  lo       out  DATA_W  LO register
//  md_outE  out  DATA_W  MFHI ? hi : MFLO ? lo : 0 (combinational)
//  md_selE  out  1       E holds valid MFHI/MFLO; ALU result mux selects md_outE
// BEHAVIOUR
//  - Decode: op=instr[31:26]=0, funct=instr[5:0]. Funct codes: MULT 18, MULTU 19,
//    DIV 1A, DIVU 1B, MFHI 10, MFLO 12, MTHI 11, MTLO 13 (hex).
//  - Reset: state IDLE, counter 0, pending result 0, hi=0, lo=0, busy=0. Reset is async
//    and aborts any operation in flight; HI/LO are not updated by it.
//  - States: IDLE, MUL, DIV.
//    - IDLE -> MUL/DIV on a clk edge with validE & start, start = MULT|MULTU|DIV|DIVU in E.
//      The same edge loads counter = MULT_CYCLES or DIV_CYCLES.
//    - The same edge latches the full result into pending:
//      - mult: 2*DATA_W product, signed or unsigned.
//      - div: quotient -> LO, remainder -> HI; signed division truncates toward zero,
//        and the remainder takes the sign of the dividend.
//    - MUL/DIV: counter decrements each edge. At the edge where counter==1: hi/lo <= pending,
//      state -> IDLE, counter -> 0.
//    - busy = (state != IDLE). For N cycles, busy is high for exactly N cycles, starting
//      the cycle after the start edge.
//  - Divide by zero: busy timing unchanged; hi/lo keep their prior values at completion.
//  - Signed overflow: -2^(DATA_W-1) / -1 gives lo=0x8000_0000, hi=0 (DATA_W=32).
//  - MTHI/MTLO: when validE and IDLE, hi (or lo) <= rsE at the next edge. Single cycle, no busy.
//  - MFHI/MFLO: md_outE reads the current hi/lo combinationally, with no extra latency.
//  - stallD = mdD & (busy | (validE & startE)), where mdD = any MD-class instruction in D.
//    A dependent MD instruction is held until the edge after busy falls.
//  - Protocol violations: start or MT* arriving in E while busy is ignored; state and
//    hi/lo are unchanged. stallD is designed to prevent this.
//  - Simultaneous events: completion edge and an MTHI on the same edge cannot occur
//    (MTHI would be stalled). A start in E on the cycle right after completion is legal.
//  - Non-MD instructions never affect state; md_selE=0 for them.
//  - Counter width = $clog2(max(MULT_CYCLES,DIV_CYCLES)+1). No wrap: counter never
//    decrements below 1 while busy.
// TESTING
//  1. Reset mid-DIV:
//     - Stimulus: DIV 7/2 started, then rst_n pulled low on its 3rd busy cycle.
//     - Response: busy=0 immediately; hi=lo=0; no late write after rst_n releases.
//  2. MULT latency:
//     - Stimulus: MULT rs=0xFFFF_FFFE, rt=3.
//     - Response: busy high exactly 5 cycles, then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA;
//       MULTU on the same operands gives hi=0x0000_0002, lo=0xFFFF_FFFA.
//  3. Signed DIV:
//     - Stimulus: DIV -7/2.
//     - Response: after 10 cycles, lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
//       DIVU 7/0 leaves hi/lo unchanged; busy still lasts 10 cycles.
//  4. Hazard stall:
//     - Stimulus: MULT in E with MFLO in D.
//     - Response: stallD high on the start cycle and all 5 busy cycles; MFLO reaches E on
//       the 7th cycle and md_outE equals the new lo. ADDU in D during busy: stallD=0.
//  5. MTHI/MTLO:
//     - Stimulus: MTHI rs=0x1234_5678 then MFHI back-to-back.
//     - Response: hi=0x1234_5678 one edge later; md_outE=0x1234_5678 with md_selE=1.
//  6. Bubbles:
//     - Stimulus: MULT encoding in E with validE=0.
//     - Response: busy stays 0 and hi/lo are unchanged.

Source files
------------

// File: rtl/md_ctrl_unit.sv
// Multiply/divide control unit: decodes MD-class instructions in D/E, sequences
// multi-cycle MULT/DIV, owns HI/LO and drives the D-stage structural stall.
module md_ctrl_unit #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instrD,
    input  logic [31:0]       instrE,
    input  logic              validE,
    input  logic [DATA_W-1:0] rsE,
    input  logic [DATA_W-1:0] rtE,
    output logic              busy,
    output logic              stallD,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] md_outE,
    output logic              md_selE
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    function automatic logic is_fn(input logic [31:0] ins, input logic [5:0] fn);
        return (ins[31:26] == 6'd0) && (ins[5:0] == fn);
    endfunction

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] pend_hi_q, pend_hi_d;
    logic [DATA_W-1:0] pend_lo_q, pend_lo_d;
    logic              pend_wr_q, pend_wr_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;

    logic multE, multuE, divE, divuE, mfhiE, mfloE, mthiE, mtloE;
    logic startE, mdD, idle, go, done;

    assign multE  = is_fn(instrE, FN_MULT);
    assign multuE = is_fn(instrE, FN_MULTU);
    assign divE   = is_fn(instrE, FN_DIV);
    assign divuE  = is_fn(instrE, FN_DIVU);
    assign mfhiE  = is_fn(instrE, FN_MFHI);
    assign mfloE  = is_fn(instrE, FN_MFLO);
    assign mthiE  = is_fn(instrE, FN_MTHI);
    assign mtloE  = is_fn(instrE, FN_MTLO);
    assign startE = multE | multuE | divE | divuE;

    assign mdD = is_fn(instrD, FN_MULT) | is_fn(instrD, FN_MULTU) |
                 is_fn(instrD, FN_DIV)  | is_fn(instrD, FN_DIVU)  |
                 is_fn(instrD, FN_MFHI) | is_fn(instrD, FN_MFLO)  |
                 is_fn(instrD, FN_MTHI) | is_fn(instrD, FN_MTLO);

    assign idle = (state_q == S_IDLE);
    assign go   = idle & validE & startE;
    assign done = !idle && (cnt_q == CW'(1));

    // Result is computed in full on the start edge and parked until completion.
    logic [DATA_W-1:0]   res_hi, res_lo;
    logic                res_wr;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   mag_a, mag_b, quo, rem;
    logic                neg_a, neg_b;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        prod   = '0;
        mag_a  = '0;
        mag_b  = '0;
        quo    = '0;
        rem    = '0;
        neg_a  = 1'b0;
        neg_b  = 1'b0;
        if (multE) begin
            prod   = {{DATA_W{rsE[DATA_W-1]}}, rsE} * {{DATA_W{rtE[DATA_W-1]}}, rtE};
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
            res_wr = 1'b1;
        end else if (multuE) begin
            prod   = {{DATA_W{1'b0}}, rsE} * {{DATA_W{1'b0}}, rtE};
            res_hi = prod[2*DATA_W-1:DATA_W];
            res_lo = prod[DATA_W-1:0];
            res_wr = 1'b1;
        end else if ((divE | divuE) && (rtE != '0)) begin
            // Signed divide via magnitudes; MIN/-1 wraps back to MIN with zero remainder.
            neg_a  = divE & rsE[DATA_W-1];
            neg_b  = divE & rtE[DATA_W-1];
            mag_a  = neg_a ? -rsE : rsE;
            mag_b  = neg_b ? -rtE : rtE;
            quo    = mag_a / mag_b;
            rem    = mag_a % mag_b;
            res_lo = (neg_a ^ neg_b) ? -quo : quo;
            res_hi = neg_a ? -rem : rem;
            res_wr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = (multE | multuE) ? S_MUL : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (done) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = !idle;
        stallD  = mdD & (busy | (validE & startE));
        md_selE = validE & (mfhiE | mfloE);
        md_outE = mfhiE ? hi_q : (mfloE ? lo_q : '0);
        hi      = hi_q;
        lo      = lo_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        if (go) begin
            cnt_d     = (multE | multuE) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            pend_wr_d = res_wr;
        end else if (!idle) begin
            cnt_d = done ? '0 : cnt_q - CW'(1);
        end
        if (done && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
        end else if (idle && validE) begin
            if (mthiE) hi_d = rsE;
            if (mtloE) lo_d = rsE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

endmodule
